// File: rtl/ycbcr_block_sequencer_pkg.sv
// Shared types and block geometry for the YCbCr raster-to-block sequencer.
package ycbcr_block_sequencer_pkg;

    localparam int DCT_DW   = 10;
    localparam int BLK_DIM  = 8;
    localparam int BLK_SIZE = BLK_DIM * BLK_DIM;

    typedef struct packed {
        logic              valid;
        logic [DCT_DW-1:0] data;
    } dctPort_t;

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        STREAM
    } seqState_t;

endpackage

// File: rtl/ycbcr_block_sequencer_if.sv
// Pixel-in / block-out bundle between colour transform, sequencer and DCT.
interface ycbcr_block_sequencer_if;
    import ycbcr_block_sequencer_pkg::*;

    dctPort_t in  [3];
    dctPort_t out [3];
    logic     out_ready;
    logic     blk_first;
    logic     blk_last;
    logic     frame_last;
    logic     overflow;

    modport master (
        output in, out_ready,
        input  out, blk_first, blk_last, frame_last, overflow
    );

    modport slave (
        input  in, out_ready,
        output out, blk_first, blk_last, frame_last, overflow
    );

endinterface

// File: rtl/ycbcr_block_sequencer_band_ram.sv
// Simple dual-port band buffer: one write port, one registered read port that
// holds its output when read-enable is low.
module band_ram #(
    parameter int DATA_WIDTH = 10,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic                  re,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/ycbcr_block_sequencer.sv
// Buffers 8-line bands of Y/Cb/Cr in a ping-pong RAM and streams them out as
// row-major 8x8 blocks under a ready handshake.
//   state  | meaning
//   IDLE   | waiting for the read bank to fill
//   FETCH  | first RAM read of a band in flight
//   STREAM | output register valid, advancing on accept
module ycbcr_block_sequencer
    import ycbcr_block_sequencer_pkg::*;
#(
    parameter int DATA_WIDTH = DCT_DW,
    parameter int IMG_WIDTH  = 640,
    parameter int IMG_HEIGHT = 480
) (
    input logic                    clk,
    input logic                    rst_n,
    ycbcr_block_sequencer_if.slave bus
);

    localparam int OFF_W  = $clog2(BLK_DIM * IMG_WIDTH);
    localparam int COL_W  = $clog2(IMG_WIDTH);
    localparam int ROW_W  = $clog2(BLK_DIM);
    localparam int SMP_W  = $clog2(BLK_SIZE);
    localparam int BLKS   = IMG_WIDTH / BLK_DIM;
    localparam int BANDS  = IMG_HEIGHT / BLK_DIM;
    localparam int BLK_W  = (BLKS > 1) ? $clog2(BLKS) : 1;
    localparam int BAND_W = (BANDS > 1) ? $clog2(BANDS) : 1;

    logic [COL_W-1:0]  wcol;
    logic [ROW_W-1:0]  wrow;
    logic              wb;
    logic              rb, rb_nxt;
    logic [1:0]        full, full_nxt;
    logic              overflow_q;
    logic              pix_valid, wr_en, wr_end;
    logic [OFF_W-1:0]  waddr_off;

    seqState_t         state, state_nxt;
    logic [SMP_W-1:0]  smp, smp_nxt;
    logic [BLK_W-1:0]  blk, blk_nxt;
    logic [BAND_W-1:0] band, band_nxt;
    logic              band_done, rd_en, st_valid, first_w, last_w;
    logic [OFF_W:0]    raddr;
    logic [DATA_WIDTH-1:0] rdata [3];

    assign pix_valid = bus.in[0].valid & bus.in[1].valid & bus.in[2].valid;
    assign wr_en     = pix_valid && !full[wb];
    assign wr_end    = wr_en && wrow == ROW_W'(BLK_DIM-1) && wcol == COL_W'(IMG_WIDTH-1);
    assign waddr_off = OFF_W'(int'(wrow) * IMG_WIDTH + int'(wcol));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wcol       <= '0;
            wrow       <= '0;
            wb         <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            if (pix_valid && full[wb]) overflow_q <= 1'b1;
            if (wr_en) begin
                if (wcol == COL_W'(IMG_WIDTH-1)) begin
                    wcol <= '0;
                    wrow <= wrow + 1'b1;
                    if (wrow == ROW_W'(BLK_DIM-1)) wb <= ~wb;
                end else begin
                    wcol <= wcol + 1'b1;
                end
            end
        end
    end

    always_comb begin
        full_nxt = full;
        if (wr_end)    full_nxt[wb] = 1'b1;
        if (band_done) full_nxt[rb] = 1'b0;
    end

    // Counters always describe the sample in the output register; the RAM is
    // addressed with their next value so a stall simply re-reads the same word.
    always_comb begin
        state_nxt = state;
        smp_nxt   = smp;
        blk_nxt   = blk;
        band_nxt  = band;
        rb_nxt    = rb;
        band_done = 1'b0;
        case (state)
            IDLE:   if (full[rb]) state_nxt = FETCH;
            FETCH:  state_nxt = STREAM;
            STREAM: if (bus.out_ready) begin
                smp_nxt = smp + 1'b1;
                if (smp == SMP_W'(BLK_SIZE-1)) begin
                    if (blk == BLK_W'(BLKS-1)) begin
                        blk_nxt   = '0;
                        band_done = 1'b1;
                        rb_nxt    = ~rb;
                        band_nxt  = (band == BAND_W'(BANDS-1)) ? '0 : band + 1'b1;
                        state_nxt = (full[~rb] || (wr_end && wb != rb)) ? FETCH : IDLE;
                    end else begin
                        blk_nxt = blk + 1'b1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            smp   <= '0;
            blk   <= '0;
            band  <= '0;
            rb    <= 1'b0;
            full  <= 2'b00;
        end else begin
            state <= state_nxt;
            smp   <= smp_nxt;
            blk   <= blk_nxt;
            band  <= band_nxt;
            rb    <= rb_nxt;
            full  <= full_nxt;
        end
    end

    assign rd_en = (state == FETCH) || (state == STREAM);
    assign raddr = {rb_nxt, OFF_W'(int'(smp_nxt[SMP_W-1:ROW_W]) * IMG_WIDTH
                                   + int'(blk_nxt) * BLK_DIM
                                   + int'(smp_nxt[ROW_W-1:0]))};

    for (genvar g = 0; g < 3; g++) begin : g_comp
        band_ram #(
            .DATA_WIDTH(DATA_WIDTH),
            .ADDR_WIDTH(OFF_W + 1)
        ) u_ram (
            .clk   (clk),
            .we    (wr_en),
            .waddr ({wb, waddr_off}),
            .wdata (DATA_WIDTH'(bus.in[g].data)),
            .re    (rd_en),
            .raddr (raddr),
            .rdata (rdata[g])
        );
        // RAM output is not reset, so data is forced to 0 while not valid.
        assign bus.out[g] = {st_valid, st_valid ? DCT_DW'(rdata[g]) : DCT_DW'(0)};
    end

    assign st_valid       = (state == STREAM);
    assign first_w        = st_valid && smp == '0;
    assign last_w         = st_valid && smp == SMP_W'(BLK_SIZE-1);
    assign bus.blk_first  = first_w;
    assign bus.blk_last   = last_w;
    assign bus.frame_last = last_w && blk == BLK_W'(BLKS-1) && band == BAND_W'(BANDS-1);
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_ycbcr_block_sequencer.sv
// Directed bench for ycbcr_block_sequencer on a 16x16 image.
module tb_ycbcr_block_sequencer;
    import ycbcr_block_sequencer_pkg::*;

    localparam int W = 16;
    localparam int H = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    initial forever #5 clk = ~clk;

    ycbcr_block_sequencer_if bus ();

    ycbcr_block_sequencer #(
        .DATA_WIDTH (10),
        .IMG_WIDTH  (W),
        .IMG_HEIGHT (H)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    logic [63:0] rx_q  [$];
    logic [63:0] exp_q [$];
    int          rx_cyc[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] pack_out();
        return {31'b0, bus.frame_last, bus.blk_last, bus.blk_first,
                bus.out[2].data, bus.out[1].data, bus.out[0].data};
    endfunction

    function automatic logic [63:0] exp_word(input int p, input bit first, input bit last, input bit fl);
        return {31'b0, fl, last, first, 10'(p + 2), 10'(p + 1), 10'(p)};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        for (int i = 0; i < 3; i++) begin
            bus.in[i].valid = 1'b0;
            bus.in[i].data  = '0;
        end
    endtask

    task automatic feed_pixel(input int p);
        for (int i = 0; i < 3; i++) begin
            bus.in[i].valid = 1'b1;
            bus.in[i].data  = 10'(p + i);
        end
        tick();
    endtask

    // pb: which band of the picture the pixel values come from
    task automatic feed_band(input int pb);
        for (int row = 0; row < 8; row++)
            for (int col = 0; col < W; col++)
                feed_pixel((pb * 8 + row) * W + col);
        idle_in();
    endtask

    // sb: band index the sequencer is on, which decides frame_last
    task automatic expect_band(input int pb, input int sb);
        for (int n = 0; n < 8 * W; n++) begin
            int b = n / 64;
            int s = n % 64;
            int p = (pb * 8 + s / 8) * W + b * 8 + s % 8;
            exp_q.push_back(exp_word(p, s == 0, s == 63, s == 63 && b == W / 8 - 1 && sb == H / 8 - 1));
        end
    endtask

    task automatic wait_rx(input int n, input string tag);
        for (int k = 0; k < 3000 && rx_q.size() < n; k++) tick();
        check({tag, "_count"}, 64'(rx_q.size() >= n ? n : rx_q.size()), 64'(n));
    endtask

    task automatic compare_rx(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            logic [63:0] got;
            logic [63:0] exp;
            got = (rx_q.size() > 0)  ? rx_q.pop_front()  : 64'hdead_dead_dead_dead;
            exp = (exp_q.size() > 0) ? exp_q.pop_front() : 64'hbeef_beef_beef_beef;
            check($sformatf("%s[%0d]", tag, i), got, exp);
        end
        if (rx_cyc.size() >= n) rx_cyc = rx_cyc[n:$];
    endtask

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Capture accepted samples and verify the output holds during stalls.
    initial begin
        logic [63:0] held;
        bit          held_v;
        held_v = 1'b0;
        held   = '0;
        forever begin
            @(negedge clk);
            if (held_v && bus.out[0].valid) check("stall_hold", pack_out(), held);
            held_v = bus.out[0].valid && !bus.out_ready;
            held   = pack_out();
            if (bus.out[0].valid && bus.out_ready) begin
                rx_q.push_back(pack_out());
                rx_cyc.push_back(cyc);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.out_ready = 1'b0;
        idle_in();

        // reset with random inputs
        rst_n = 1'b0;
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 3; i++) begin
                bus.in[i].valid = 1'($urandom);
                bus.in[i].data  = 10'($urandom);
            end
            bus.out_ready = 1'($urandom);
            tick();
        end
        check("rst_valid", 64'({bus.out[0].valid, bus.out[1].valid, bus.out[2].valid}), 64'(0));
        check("rst_outputs", pack_out(), 64'(0));
        check("rst_ovf", 64'(bus.overflow), 64'(0));
        idle_in();
        bus.out_ready = 1'b0;
        rst_n = 1'b1;
        tick();
        check("post_rst_ovf", 64'(bus.overflow), 64'(0));
        check("post_rst_valid", 64'(bus.out[0].valid), 64'(0));

        // single band, always ready
        bus.out_ready = 1'b1;
        expect_band(0, 0);
        feed_band(0);
        check("lat_edge_t", 64'(bus.out[0].valid), 64'(0));
        tick();
        check("lat_fetch", 64'(bus.out[0].valid), 64'(0));
        tick();
        check("lat_valid", 64'(bus.out[0].valid), 64'(1));
        check("lat_first", pack_out(), exp_q[0]);
        wait_rx(128, "band");
        if (rx_cyc.size() >= 128)
            check("bubble_free", 64'(rx_cyc[127] - rx_cyc[0]), 64'(127));
        compare_rx("band", 128);

        // backpressure 1,0,1,0...
        bus.out_ready = 1'b0;
        expect_band(0, 1);
        feed_band(0);
        for (int k = 0; k < 1000 && rx_q.size() < 128; k++) begin
            bus.out_ready = ~bus.out_ready;
            tick();
        end
        wait_rx(128, "bp");
        compare_rx("bp", 128);

        // overflow on the 257th pixel
        bus.out_ready = 1'b0;
        feed_band(0);
        feed_band(1);
        check("ovf_256", 64'(bus.overflow), 64'(0));
        feed_pixel(256);
        idle_in();
        check("ovf_257", 64'(bus.overflow), 64'(1));
        expect_band(0, 0);
        expect_band(1, 1);
        bus.out_ready = 1'b1;
        wait_rx(256, "ovf");
        compare_rx("ovf", 256);
        check("ovf_sticky", 64'(bus.overflow), 64'(1));

        // frame end then start of next frame
        expect_band(0, 0);
        expect_band(1, 1);
        expect_band(0, 0);
        feed_band(0);
        repeat (10) tick();
        feed_band(1);
        repeat (10) tick();
        feed_band(0);
        wait_rx(384, "frame");
        compare_rx("frame", 384);

        // reset in the middle of block 1
        expect_band(0, 1);
        feed_band(0);
        wait_rx(70, "pre_rst");
        rst_n = 1'b0;
        #1;
        check("rst_async_valid", 64'(bus.out[0].valid), 64'(0));
        check("rst_async_out", pack_out(), 64'(0));
        compare_rx("pre_rst", 70);
        rx_q.delete();
        exp_q.delete();
        rx_cyc.delete();
        tick();
        rst_n = 1'b1;
        tick();
        check("rst_ovf_clear", 64'(bus.overflow), 64'(0));
        expect_band(0, 0);
        feed_band(0);
        wait_rx(128, "post_rst");
        compare_rx("post_rst", 128);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/ycbcr_block_sequencer.md
# ycbcr_block_sequencer

Reorders the raster-scan YCbCr pixel stream from the colour-transform stage into 8×8 blocks for the DCT stage. It buffers one 8-line band per component in a two-bank ping-pong buffer. It emits each block in row-major order, one sample per component per cycle, under a ready handshake from the DCT. It sits between `RGB2YCbCr` and the DCT input and owns all block, band and frame sequencing.

## Interface
- `DATA_WIDTH`, 10: bits per component sample.
- `IMG_WIDTH`, 640: pixels per line; multiple of 8, ≥ 8.
- `IMG_HEIGHT`, 480: lines per frame; multiple of 8, ≥ 8.
- `clk`  in  1  sole clock; all logic on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `in[3]`  in  dctPort_t  Y/Cb/Cr from colour transform; a pixel is present when `&{in[i].valid}`; no backpressure.
- `out[3]`  out  dctPort_t  block-ordered samples; `out[i].valid` identical for all i.
- `out_ready`  in  1  DCT accepts a sample when `out[0].valid && out_ready`.
- `blk_first`  out  1  qualifies first sample (r=0,c=0) of a block.
- `blk_last`  out  1  qualifies last sample (r=7,c=7) of a block.
- `frame_last`  out  1  with `blk_last` on the final block of the final band.
- `overflow`  out  1  sticky: an input pixel was dropped; cleared only by reset.

## Operation
- Storage: 2 banks × 3 components × (8·IMG_WIDTH) words of DATA_WIDTH. Per-bank `full` flag.
- Write side: counters `wcol` (0..W-1) and `wrow` (0..7), plus bank pointer `wb`.
  - A valid pixel with `full[wb]==0` writes address `wrow·W+wcol` and advances `wcol`, then `wrow`.
  - Writing (`wrow=7`, `wcol=W-1`) sets `full[wb]`, toggles `wb` and zeroes the counters.
  - A valid pixel with `full[wb]==1` is dropped. Counters hold, `overflow`←1.
- Read FSM, states IDLE, FETCH, STREAM:
  - IDLE: leave when `full[rb]` → FETCH.
  - FETCH: one cycle; issues the RAM read of the first address; → STREAM.
  - STREAM: output register valid.
    - On accept, advance `c`→`r`→`blk` (0..W/8-1). Next read address is `r·W + blk·8 + c`.
    - Block-to-block transitions within a band are bubble-free.
    - On accepting the last sample of the band: clear `full[rb]`, toggle `rb`, advance `band` (0..H/8-1, wraps at frame end). Next state is FETCH if the new `full[rb]`, else IDLE.
- Stall: while `valid && !out_ready`, `out[*].data`, `blk_first`, `blk_last` and `frame_last` hold stable. The RAM re-reads the current address, so no skid buffer is needed.
- Simultaneous set and clear of different banks in one cycle are both honoured. Write may set `full[wb]` in the same cycle read clears `full[rb]` (`wb≠rb` always then).
- Output data is the stored value unmodified; no arithmetic, no saturation.
- Reset value of every output is 0. Reset mid-operation discards all buffered bands: counters, pointers and flags return to 0, FSM goes to IDLE. RAM contents are not reset.

## Timing
- Write: 1 pixel/cycle sustained, no stall cycles.
- Latency: the last pixel of a band is written at edge t. `out.valid` rises after edge t+2 (FETCH at t+1) when the FSM was IDLE.
- Throughput: 64 samples per block per component; one idle cycle (FETCH) per band.
- Overflow-free requirement: the DCT must sustain ≥1 sample/cycle averaged over a band. Otherwise `overflow` flags the loss.
- Valid/ready: valid never deasserts without acceptance except on reset.

## Structure
- Shared package (alongside `dctPort_t` in `interface.sv`): `BLK_DIM=8`, `BLK_SIZE=64`, and the read-FSM enum `seqState_t {IDLE, FETCH, STREAM}`.
- Sub-module `band_ram`: simple dual-port RAM (one write port, one registered read port with read-enable/hold), DATA_WIDTH × 16·IMG_WIDTH. One instance per component, bank select as the address MSB.
- Top holds the write counters, the read FSM, the band counter and the flags.

## Test plan
Benches use IMG_WIDTH=16, IMG_HEIGHT=16.
- **Reset:** assert `rst_n=0` with random `in` → all outputs 0; `overflow=0` after release.
- **Single band, `out_ready=1`:** Y=`row·16+col`, Cb=Y+1, Cr=Y+2.
  - Block 0 Y order is 0..7, 16..23, …, 112..119. `blk_first` on 0, `blk_last` on 119.
  - Block 1 starts at 8 on the next cycle.
  - First valid arrives 2 edges after the last write.
- **Backpressure:** `out_ready` pattern 1,0,1,0… → 128 samples per component received in the same order as the previous scenario. Data stable during every stall; no duplicates.
- **Overflow:** `out_ready=0`, feed 257 pixels → `overflow` rises on the 257th. Then `out_ready=1` → pixels 0..255 (2 bands) emitted intact.
- **Frame end:** full 16×16 frame then a second frame → `frame_last` only with `blk_last` of the 4th block. The 5th block (second frame) has `blk_first` and Y=0.
- **Reset mid-STREAM:** pulse `rst_n` low during block 1 → `out.valid` drops asynchronously. A fresh band afterwards streams correctly starting at Y=0.
